// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;
    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam int ENTRY_W = XLEN + INST_W;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of {pc, inst} entries; clear beats push, head holds last value when empty.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] head,
    output logic [CW-1:0]      count
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] last;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               pop_eff;

    assign pop_eff = pop && (count != '0);
    assign head    = (count != '0) ? mem[rd_ptr] : last;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Track the visible head so the outputs freeze once the FIFO drains.
            if (count != '0) last <= mem[rd_ptr];
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wdata;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop_eff);
            end
        end
    end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem read, FIFO of fetched words, redirect flush.
module if_fetch
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         live;
    logic         push;
    logic [CW-1:0] count;
    fetch_entry_t wentry;
    fetch_entry_t hentry;
    logic         unused_low;

    assign unused_low = ^redirect_pc[1:0];

    // live keeps imem_req low while rst is held without a combinational rst path.
    assign imem_req   = live && (state == REQ) && (count < CW'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = hentry.inst;
    assign inst_pc    = hentry.pc;

    assign push          = (state == WAIT) && imem_rvalid && !redirect_en;
    assign wentry.pc     = fetch_pc;
    assign wentry.inst   = imem_rdata;

    if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (inst_ready),
        .clear (redirect_en),
        .wdata (wentry),
        .head  (hentry),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= word_align(RESET_PC);
            live     <= 1'b0;
        end else begin
            live <= 1'b1;
            if (redirect_en)  fetch_pc <= word_align(redirect_pc);
            else if (push)    fetch_pc <= fetch_pc + 32'd4;
            case (state)
                REQ: begin
                    if (imem_req && imem_gnt) state <= redirect_en ? DROP : WAIT;
                end
                WAIT: begin
                    if (imem_rvalid)      state <= REQ;
                    else if (redirect_en) state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch; a small in-order memory responder lives in the step task.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int          vectors = 0;
    int          miscompares = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    always #5 clk = ~clk;

    if_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // One clock: respond to the pending read (if rv_en), grant a visible request (if gnt_en).
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc,
                        input logic gnt_en, input logic rv_en);
        logic        g;
        logic        deliver;
        logic [31:0] a;
        deliver     = pend & rv_en;
        imem_rvalid = deliver;
        imem_rdata  = deliver ? (ovr_en ? ovr_data : word(pend_addr)) : 32'h0;
        g           = gnt_en & (imem_req === 1'b1);
        a           = imem_addr;
        imem_gnt    = g;
        inst_ready  = rdy;
        redirect_en = redir;
        redirect_pc = rpc;
        @(posedge clk); #1;
        if (deliver) begin pend = 1'b0; ovr_en = 1'b0; end
        if (g) begin pend = 1'b1; pend_addr = a; end
    endtask

    task automatic do_reset();
        rst = 1'b1; pend = 1'b0; ovr_en = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; pend = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst got %h want 0", inst); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", inst_pc); end
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL post_rst_req got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL post_rst_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1);
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stream_wait_req[%0d] got %b want 0", i, imem_req); end
            vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL stream_empty[%0d] got %b want 0", i, inst_valid); end
            if (i > 0) begin
                vectors++; if (inst_pc !== 32'(4*(i-1))) begin miscompares++; $display("FAIL stream_hold_pc[%0d] got %h want %h", i, inst_pc, 32'(4*(i-1))); end
            end
            step(1, 0, 0, 1, 1);
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, inst_valid); end
            vectors++; if (inst_pc !== 32'(4*i)) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_pc, 32'(4*i)); end
            vectors++; if (inst !== word(32'(4*i))) begin miscompares++; $display("FAIL stream_inst[%0d] got %h want %h", i, inst, word(32'(4*i))); end
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i+4)) begin miscompares++; $display("FAIL stream_addr[%0d] got req %b addr %h want 1 %h", i, imem_req, imem_addr, 32'(4*i+4)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (12) step(0, 0, 0, 1, 1);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL full_req got %b want 0", imem_req); end
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin miscompares++; $display("FAIL full_head got v %b pc %h want 1 0", inst_valid, inst_pc); end
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL full_addr got %h want 10", imem_addr); end
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 1, 1);
            vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k)) begin miscompares++; $display("FAIL drain_pc[%0d] got v %b pc %h want 1 %h", k, inst_valid, inst_pc, 32'(4*k)); end
            vectors++; if (inst !== word(32'(4*k))) begin miscompares++; $display("FAIL drain_inst[%0d] got %h want %h", k, inst, word(32'(4*k))); end
            if (k == 1) begin
                vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL resume got req %b addr %h want 1 10", imem_req, imem_addr); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h100, 1, 0);
        vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_drop got v %b req %b want 0 0", inst_valid, imem_req); end
        ovr_en = 1'b1; ovr_data = 32'h0000_DEAD;
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rw_dead_valid got %b want 0", inst_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL rw_addr got req %b addr %h want 1 100", imem_req, imem_addr); end
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== word(32'h100)) begin miscompares++; $display("FAIL rw_first got v %b pc %h inst %h want 1 100 %h", inst_valid, inst_pc, inst, word(32'h100)); end
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h80, 1, 1);
        vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin miscompares++; $display("FAIL rw_same_cycle got v %b req %b addr %h want 0 1 80", inst_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_gnt();
        do_reset();
        step(1, 1, 32'h203, 1, 1);
        vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL rg_drop got req %b v %b want 0 0", imem_req, inst_valid); end
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL rg_addr got v %b req %b addr %h want 0 1 200", inst_valid, imem_req, imem_addr); end
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== word(32'h200)) begin miscompares++; $display("FAIL rg_first got v %b pc %h inst %h want 1 200 %h", inst_valid, inst_pc, inst, word(32'h200)); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        repeat (6) step(0, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_addr !== 32'hC) begin miscompares++; $display("FAIL rf_fill got v %b pc %h addr %h want 1 0 c", inst_valid, inst_pc, imem_addr); end
        step(1, 1, 32'h40, 0, 1);
        vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL rf_flush got v %b req %b addr %h want 0 1 40", inst_valid, imem_req, imem_addr); end
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rf_stale got v %b pc %h want 0", inst_valid, inst_pc); end
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin miscompares++; $display("FAIL rf_first got v %b pc %h want 1 40", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1, 1, 32'hFFFF_FFFC, 0, 1);
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== word(32'hFFFF_FFFC)) begin miscompares++; $display("FAIL wrap_top got v %b pc %h inst %h", inst_valid, inst_pc, inst); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr got %h want 0", imem_addr); end
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== word(32'h0)) begin miscompares++; $display("FAIL wrap_zero got v %b pc %h inst %h", inst_valid, inst_pc, inst); end
    endtask

    initial begin
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit that consumes the program counter stream and produces decoded-ready instruction words: it issues read requests to instruction memory at the current fetch address, buffers returned words with their PC in a small FIFO, and hands them to decode over a valid/ready handshake. It sits between the PC generator and the instruction memory port on one side and the decode stage on the other. On a control-flow redirect it flushes buffered and in-flight fetches and restarts at the new target.

## Interface
- DEPTH, 4: instruction FIFO entries; power of two, ≥2
- RESET_PC, 32'h0: first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- redirect_en  in  1  flush and restart fetch at redirect_pc (jump/branch taken)
- redirect_pc  in  32  new fetch address; bits [1:0] ignored
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  request address; [1:0] always 0
- imem_gnt  in  1  memory accepts request this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  read data valid; in order, ≥1 cycle after gnt
- imem_rdata  in  32  instruction word
- inst_valid  out  1  FIFO head holds an instruction
- inst  out  32  head instruction word
- inst_pc  out  32  address of head instruction
- inst_ready  in  1  decode accepts head this cycle

## Operation
- Registers: fetch_pc (32), FSM state, FIFO of {pc, inst}, count.
- At most one outstanding memory transaction.
- FSM states:
  - REQ: imem_req = (count < DEPTH). On req & gnt & !redirect_en → WAIT. On req & gnt & redirect_en → DROP.
  - WAIT: imem_req = 0. On rvalid & !redirect_en: push {fetch_pc, imem_rdata}, fetch_pc ← fetch_pc + 4, → REQ. On redirect_en without rvalid → DROP. On redirect_en with rvalid → data discarded, → REQ.
  - DROP: imem_req = 0. On rvalid: discard data, → REQ. A further redirect_en here only updates fetch_pc.
- redirect_en (any state): fetch_pc ← {redirect_pc[31:2], 2'b00}; FIFO cleared (count ← 0) at end of cycle. Redirect has priority over push and over fetch_pc increment.
- A request may be withdrawn: imem_req dropping without gnt is legal on this port (redirect in REQ).
- Output handshake: pop on inst_valid & inst_ready. In a redirect cycle, the handshake still completes from decode's view; the FIFO is cleared regardless.
- Simultaneous push and pop: both take effect, count unchanged; push into full FIFO impossible by construction (req gated on count < DEPTH with no outstanding transaction).
- fetch_pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- inst_valid = (count != 0); inst/inst_pc reflect head slot, held at last value when empty.

## Timing
- Reset values: state REQ, fetch_pc = RESET_PC, count 0, FIFO slots 0; outputs during rst: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0.
- First cycle after rst deasserts: imem_req 1, imem_addr RESET_PC.
- imem_req, imem_addr, inst_valid, inst, inst_pc are functions of registers only; no combinational input-to-output path.
- Latency: gnt at T, rvalid at T+1 → inst_valid at T+2. Best-case throughput one instruction per 2 cycles.
- Redirect at cycle R: inst_valid 0 at R+1; request to new target at R+1 if no transaction is outstanding, else the cycle after the dropped rvalid.
- rst mid-transaction: state to REQ; memory side is reset in the same cycle, so no stale rvalid is expected.

## Structure
- Shared package if_pkg: RESET_PC default, INST_W=32, XLEN=32, FSM state encoding (REQ, WAIT, DROP).
- One sub-module: if_fifo — synchronous FIFO, DEPTH × 64-bit {pc, inst}, push/pop/clear, count, registered storage, clear has priority over push.

## Test plan
- Reset then gnt immediate, rvalid 1 cycle later, inst_ready held 1 → imem_addr 0,4,8,…; inst_pc 0,4,8 with matching inst, one per 2 cycles.
- inst_ready held 0 → exactly DEPTH (4) entries buffered, imem_req stays 0; raise inst_ready → drains in order, fetch resumes at 0x10.
- Redirect to 0x100 while in WAIT; rvalid arrives next cycle with 0xDEAD → word dropped, inst_valid 0, next imem_addr 0x100.
- Redirect to 0x203 in the same cycle as gnt → next response dropped; next request at 0x200; first delivered inst_pc 0x200.
- Redirect with FIFO holding 3 entries and inst_ready=1 → count 0 next cycle; no stale PC ever appears on inst_pc.
- Redirect to 0xFFFF_FFFC, two fetches → inst_pc 0xFFFF_FFFC then 0x0000_0000.
